// File: rtl/wbs_hword_ram_if.sv
// Wishbone B.4 pipelined bus bundle for the 16-bit halfword RAM slave.
// Master drives the request side; the slave returns ack, read data and stall.
interface wbs_hword_ram_if;
   logic [63:0] wbsadr;
   logic [15:0] wbsdat_wr;
   logic [15:0] wbsdat_rd;
   logic        wbswe;
   logic [1:0]  wbssel;
   logic        wbsstb;
   logic        wbscyc;
   logic        wbsack;
   logic        wbsstall;

   modport master (
      output wbsadr, wbsdat_wr, wbswe, wbssel, wbsstb, wbscyc,
      input  wbsdat_rd, wbsack, wbsstall
   );

   modport slave (
      input  wbsadr, wbsdat_wr, wbswe, wbssel, wbsstb, wbscyc,
      output wbsdat_rd, wbsack, wbsstall
   );
endinterface

// File: rtl/wbs_hword_ram.sv
// Wishbone B.4 pipelined slave over a byte-lane halfword RAM: one request per
// clock, writes commit at the strobe edge, in-order acks after LATENCY cycles.
module wbs_hword_ram #(
   parameter int ADDR_BITS = 10,
   parameter int LATENCY   = 1
) (
   input logic            clk_i,
   input logic            reset_ni,
   wbs_hword_ram_if.slave bus
);
   generate
      if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
         $error("wbs_hword_ram: LATENCY must be in 1..4");
      end
   endgenerate

   localparam int DEPTH = 1 << ADDR_BITS;

   logic [ADDR_BITS-1:0] idx;
   logic                 accept;
   logic [15:0]          lane_mask;
   logic [15:0]          rd_word;
   logic                 stage1_valid_next;
   logic [15:0]          stage1_data_next;
   logic                 valid_reg [1:LATENCY];
   logic [15:0]          data_reg  [1:LATENCY];
   logic                 unused_adr;

   assign idx        = bus.wbsadr[ADDR_BITS:1];
   assign accept     = bus.wbscyc & bus.wbsstb;
   assign lane_mask  = {{8{bus.wbssel[1]}}, {8{bus.wbssel[0]}}};
   assign unused_adr = ^{bus.wbsadr[63:ADDR_BITS+1], bus.wbsadr[0]};

   // One byte-wide RAM per lane so each lane's write enable stays independent.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];

         always_ff @(posedge clk_i) begin
            if (accept && bus.wbswe && bus.wbssel[gi]) begin
               mem[idx] <= bus.wbsdat_wr[8*gi +: 8];
            end
         end

         assign rd_word[8*gi +: 8] = mem[idx];
      end
   endgenerate

   always_comb begin
      stage1_valid_next = accept;
      stage1_data_next  = 16'h0000;
      if (accept && !bus.wbswe) begin
         stage1_data_next = rd_word & lane_mask;
      end
   end

   // Dropping wbscyc aborts everything in flight; committed writes stay.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int k = 1; k <= LATENCY; k++) begin
            valid_reg[k] <= 1'b0;
            data_reg[k]  <= 16'h0000;
         end
      end else if (!bus.wbscyc) begin
         for (int k = 1; k <= LATENCY; k++) begin
            valid_reg[k] <= 1'b0;
            data_reg[k]  <= 16'h0000;
         end
      end else begin
         valid_reg[1] <= stage1_valid_next;
         data_reg[1]  <= stage1_data_next;
         for (int k = 2; k <= LATENCY; k++) begin
            valid_reg[k] <= valid_reg[k-1];
            data_reg[k]  <= data_reg[k-1];
         end
      end
   end

   assign bus.wbsack    = valid_reg[LATENCY] & bus.wbscyc;
   assign bus.wbsdat_rd = bus.wbsack ? data_reg[LATENCY] : 16'h0000;
   assign bus.wbsstall  = 1'b0;
endmodule
